apb4_mem_slave: RTL and testbench

Parametrised APB4 completer wrapping a word-addressed memory, the successor of the team's fixed 32-bit APB slave. It adds configurable data width, depth and wait states, byte strobes (PSTRB), a read-only upper region, a privileged-write check (PPROT[0]), and alignment and range error reporting. It sits behind the APB interconnect as a generic scratch/config memory target.

---
 rtl/apb4_mem_slave.sv | 108 ++++++++++
 tb/tb_apb4_mem_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
// APB4 completer over a word-addressed memory: configurable width, depth and wait
// states, byte strobes, read-only upper region, privileged-write and alignment/range errors.
module apb4_mem_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_BASE     = DEPTH,
   parameter bit PRIV_WRITE  = 1'b0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSELx,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int BL = $clog2(NB);
   localparam int IW = ADDR_WIDTH - BL;
   localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);
   localparam logic [IW:0] RO_L    = (IW+1)'(RO_BASE);

   // The setup phase is the IDLE cycle with PSELx=1, PENABLE=0; leaving it loads the counter.
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t state, state_n;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [3:0]            cnt;
   logic [IW-1:0]         idx;
   logic [MW-1:0]         mem_idx;
   logic                  misal, oor, ro_hit, priv_bad, err;
   logic                  start, waiting, load_rdy, complete, wr_en;
   logic                  unused_ok;

   assign idx     = PADDR[ADDR_WIDTH-1:BL];
   assign mem_idx = idx[MW-1:0];

   if (BL > 0) begin : g_align
      assign misal = |PADDR[BL-1:0];
   end else begin : g_noalign
      assign misal = 1'b0;
   end

   assign oor      = ({1'b0, idx} >= DEPTH_L);
   assign ro_hit   = ({1'b0, idx} >= RO_L);
   assign priv_bad = PRIV_WRITE && !PPROT[0];
   assign err      = misal || oor || (PWRITE && (ro_hit || priv_bad));
   assign unused_ok = ^PPROT[2:1];

   assign start    = (state == IDLE) && PSELx && !PENABLE;
   assign waiting  = (state == ACCESS) && PSELx && !PREADY;
   assign load_rdy = (start && (WAIT_CYCLES == 0)) || (waiting && (cnt == 4'd1));
   assign complete = (state == ACCESS) && PREADY && PSELx && PENABLE;
   assign wr_en    = complete && PWRITE && !err;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (PSELx && !PENABLE) state_n = ACCESS;
         ACCESS:  if (!PSELx || PREADY) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are single-cycle pulses: cleared every edge unless the ready edge is reached.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt     <= 4'd0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         if (start)
            cnt <= 4'(WAIT_CYCLES);
         else if (waiting && (cnt != 4'd0))
            cnt <= cnt - 4'd1;
         if (load_rdy) begin
            PREADY  <= 1'b1;
            PSLVERR <= err;
            PRDATA  <= (!err && !PWRITE) ? mem[mem_idx] : '0;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (PSTRB[b]) mem[mem_idx][8*b +: 8] <= PWDATA[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: two instances (no wait states / 3 wait states with a
// read-only region and privileged writes) driven by one stimulus process.
module tb_apb4_mem_slave;
   typedef struct packed {
      logic [31:0] rd;
      logic        err;
      logic        chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  psel, pen, pwr, prdy, perr;
   logic [31:0] paddr [2];
   logic [31:0] pwdata [2];
   logic [3:0]  pstrb [2];
   logic [2:0]  pprot [2];
   logic [31:0] prdata [2];

   logic [31:0] m  [2][1024];
   logic [3:0]  kn [2][1024];
   exp_t        q0 [$];
   exp_t        q1 [$];
   int          age [2];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
      .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
      .PRDATA(prdata[0]), .PREADY(prdy[0]), .PSLVERR(perr[0]));

   apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(3),
                    .RO_BASE(512), .PRIV_WRITE(1'b1)) dut1 (
      .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
      .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
      .PRDATA(prdata[1]), .PREADY(prdy[1]), .PSLVERR(perr[1]));

   function automatic int ws(input int d);
      return (d == 1) ? 3 : 0;
   endfunction

   function automatic longint ro_base(input int d);
      return (d == 1) ? 64'd512 : 64'd1024;
   endfunction

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
   endtask

   // Reference: error rules and byte-merge applied to a plain array, with byte-known tracking.
   function automatic exp_t model(input int d, input bit wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      exp_t   e;
      longint idx;
      bit     err;
      idx = longint'(a) / 4;
      err = (a % 4 != 0) || (idx >= 1024) || (wr && idx >= ro_base(d)) || (wr && d == 1 && !pr[0]);
      e.rd  = 32'h0;
      e.err = err;
      e.chk = 1'b1;
      if (!err && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (st[b]) begin
               m[d][int'(idx)][8*b +: 8] = wd[8*b +: 8];
               kn[d][int'(idx)][b] = 1'b1;
            end
         end
      end else if (!err) begin
         e.rd  = m[d][int'(idx)];
         e.chk = (kn[d][int'(idx)] == 4'hF);
      end
      return e;
   endfunction

   task automatic drive_setup(input int d, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr;
      paddr[d] = a; pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
   endtask

   task automatic wait_ready(input int d);
      int n;
      n = 0;
      while (!prdy[d] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!prdy[d]) begin
         n_chk++;
         $display("FAIL pready_timeout dut%0d: got 0 expected 1 within 40 cycles", d);
      end
   endtask

   task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      exp_t e;
      e = model(d, wr, a, wd, st, pr);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      drive_setup(d, wr, a, wd, st, pr);
      @(posedge clk); #1 pen[d] = 1'b1;
      wait_ready(d);
      @(posedge clk); #1;
      psel[d] = 1'b0; pen[d] = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
               if (psel[d] && !pen[d]) age[d] = 0;
               else if (psel[d])       age[d]++;
               if (prdy[d]) begin
                  if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                     n_chk++;
                     $display("FAIL unexpected_pready dut%0d: got 1 expected 0 (no transfer pending)", d);
                  end else begin
                     if (d == 0) e = q0.pop_front();
                     else        e = q1.pop_front();
                     chk("ready_latency", d, 64'(age[d]), 64'(ws(d) + 1));
                     chk("pslverr", d, 64'(perr[d]), 64'(e.err));
                     if (e.chk) chk("prdata", d, 64'(prdata[d]), 64'(e.rd));
                  end
               end else begin
                  chk("idle_outputs", d, {31'h0, perr[d], prdata[d]}, 64'h0);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a, v;
      int          r;
      psel = '0; pen = '0; pwr = '0;
      for (int d = 0; d < 2; d++) begin
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0; age[d] = 0;
      end
      for (int d = 0; d < 2; d++) for (int w = 0; w < 1024; w++) kn[d][w] = 4'h0;

      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++)
         chk("reset_outputs", d, {30'h0, prdy[d], perr[d], prdata[d]}, 64'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      for (int w = 0; w < 64; w++)
         for (int d = 0; d < 2; d++) xfer(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 3'b001);

      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
      xfer(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b001);
      idle(2);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
      xfer(1, 1'b1, 32'h14, 32'h01234567, 4'hF, 3'b001);
      xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000);

      xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000);
      xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b000);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
      chk("strobe_merge_model", 0, 64'(m[0][8]), 64'h11BB33DD);
      xfer(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 3'b000);
      xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000);

      xfer(0, 1'b0, 32'h1001, 32'h0, 4'hF, 3'b000);
      xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000);
      xfer(0, 1'b1, 32'h11, 32'h55555555, 4'hF, 3'b000);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
      xfer(1, 1'b1, 32'h800, 32'h12345678, 4'hF, 3'b001);
      xfer(1, 1'b1, 32'h40, 32'h87654321, 4'hF, 3'b000);
      xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);

      // Reset pulse in the ready cycle of a write: outputs clear at once, no commit.
      xfer(1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'b001);
      drive_setup(1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 3'b001);
      @(posedge clk); #1 pen[1] = 1'b1;
      wait_ready(1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", 1, {30'h0, prdy[1], perr[1], prdata[1]}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; psel[1] = 1'b0; pen[1] = 1'b0;
      idle(1);
      xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000);

      // PSELx dropped mid-wait: the transfer is abandoned.
      drive_setup(1, 1'b1, 32'h44, 32'h0BADF00D, 4'hF, 3'b001);
      @(posedge clk); #1 pen[1] = 1'b1;
      @(posedge clk); #1 psel[1] = 1'b0; pen[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("abort_no_ready", 1, 64'(prdy[1]), 64'h0);
         @(posedge clk); #1;
      end
      xfer(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
      xfer(1, 1'b1, 32'h44, 32'h600DCAFE, 4'hF, 3'b001);
      xfer(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'($urandom_range(1024, 4095) * 4);
            else if (r == 2) a = 32'($urandom_range(512, 1023) * 4);
            else             a = 32'($urandom_range(0, 63) * 4);
            v = $urandom;
            xfer(d, 1'($urandom_range(0, 1)), a, v, 4'($urandom_range(0, 15)),
                 {2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)});
            idle($urandom_range(0, 2));
         end
      end

      idle(10);
      chk("scoreboard_drained", 0, 64'(q0.size() + q1.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
